// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage.
//   - Fetch FSM state type and state encodings (RUN / WAIT / DROP)
//   - PC_STEP: byte increment between sequential instruction words
//   - fetch_entry_t: one buffered fetch result {pc, instr} at default widths
// Optional feature macro used by instr_fetch_unit: FETCH_PERF_EN
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned FETCH_PC_W  = 9;
    localparam int unsigned FETCH_INS_W = 32;
    localparam int unsigned PC_STEP     = 4;

    // RUN : nothing outstanding
    // WAIT: one read outstanding, its word will be kept
    // DROP: one read outstanding, its word is stale and will be discarded
    typedef logic [1:0] fetch_state_e;
    localparam fetch_state_e RUN  = 2'd0;
    localparam fetch_state_e WAIT = 2'd1;
    localparam fetch_state_e DROP = 2'd2;

    typedef struct packed {
        logic [FETCH_PC_W-1:0]  pc;
        logic [FETCH_INS_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the instruction-memory read channel and the decode handshake of the
// fetch stage.
//   master : fetch unit side (drives imem_req/imem_addr and id_valid/id_instr/id_pc)
//   slave  : environment side (instruction memory + decode)
// Signals:
//   imem_req, imem_addr[PC_W]   read request and byte address
//   imem_rvalid, imem_rdata     read response
//   id_valid, id_ready          decode handshake
//   id_instr[INS_W], id_pc[PC_W] head-of-buffer instruction and its PC
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32
);
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_rvalid;
    logic [INS_W-1:0] imem_rdata;
    logic             id_valid;
    logic             id_ready;
    logic [INS_W-1:0] id_instr;
    logic [PC_W-1:0]  id_pc;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc,
        input  imem_rvalid, imem_rdata, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc,
        output imem_rvalid, imem_rdata, id_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO buffering fetched {pc, instr} words.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   flush            drop all entries (same effect as reset on the control state)
//   push, push_data  write one entry (caller guarantees not full)
//   pop              remove head entry (caller guarantees not empty)
//   count            current occupancy, 0..DEPTH
//   head_valid       registered "not empty"
//   head_data        entry at the read pointer
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 41,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             valid_r;
    logic [CNT_W-1:0] count_next_s;

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_next_s = count_r;
        case ({push, pop})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointer, occupancy and registered head-valid state
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
            valid_r <= (count_next_s != {CNT_W{1'b0}});
        end
    end

    // Entry storage; contents need no reset because valid_r gates them
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign count      = count_r;
    assign head_valid = valid_r;
    assign head_data  = mem_r[rd_ptr_r];

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Instruction-fetch stage: owns the PC, issues word reads to instruction memory
// (at most one outstanding), buffers returned words with their PCs in
// fetch_fifo and presents the head to decode via valid/ready. A redirect
// flushes the buffer, loads a new (word-aligned) PC and marks any outstanding
// read as stale so its word is discarded on arrival.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   redirect_valid, redirect_pc   flush + new PC (bits [1:0] ignored)
//   fetch_bus (master)            imem request/response and decode handshake
//   perf_fetched, perf_bubble     (FETCH_PERF_EN only) pop / starved-cycle counters
// Build option: define FETCH_PERF_EN to add the performance counters.
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W       = 9,
    parameter int              INS_W      = 32,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [PC_W-1:0] RESET_PC   = {PC_W{1'b0}}
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_pc,
    instr_fetch_unit_if.master  fetch_bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_bubble
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Clear the byte-offset bits of a PC
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
        return a & {{(PC_W-2){1'b1}}, 2'b00};
    endfunction

    fetch_state_e      state_r;
    fetch_state_e      state_n_s;
    logic [PC_W-1:0]   pc_r;
    logic [PC_W-1:0]   pc_n_s;
    logic [PC_W-1:0]   req_pc_r;
    logic [CNT_W-1:0]  count_s;
    logic [CNT_W-1:0]  count_after_s;
    logic              head_valid_s;
    logic [PC_W+INS_W-1:0] head_data_s;
    logic              push_s;
    logic              pop_s;
    logic              slot_s;
    logic              room_s;
    logic              issue_s;

    assign pop_s  = head_valid_s & fetch_bus.id_ready & ~redirect_valid;
    assign push_s = fetch_bus.imem_rvalid & (state_r == WAIT) & ~redirect_valid;

    // Occupancy as it will be after this cycle; issuing against this lets a
    // request go out in the same cycle a response lands or the head is taken.
    assign count_after_s = count_s + CNT_W'(push_s) - CNT_W'(pop_s);
    assign room_s        = (count_after_s < CNT_W'(FIFO_DEPTH));

    // The single outstanding slot is free now, or frees up this cycle.
    assign slot_s  = (state_r == RUN) | ((state_r != RUN) & fetch_bus.imem_rvalid);
    assign issue_s = ~reset & ~redirect_valid & slot_s & room_s;

    assign fetch_bus.imem_req  = issue_s;
    assign fetch_bus.imem_addr = pc_r;

    // Next FSM state and PC; redirect overrides everything else
    always_comb begin
        state_n_s = state_r;
        pc_n_s    = pc_r;
        if (redirect_valid) begin
            pc_n_s = align_pc(redirect_pc);
            if ((state_r != RUN) && !fetch_bus.imem_rvalid) begin
                state_n_s = DROP;
            end else begin
                state_n_s = RUN;
            end
        end else if (issue_s) begin
            pc_n_s    = pc_r + PC_W'(PC_STEP);
            state_n_s = WAIT;
        end else if (fetch_bus.imem_rvalid && (state_r != RUN)) begin
            state_n_s = RUN;
        end else begin
            state_n_s = state_r;
        end
    end

    // FSM, PC and PC-of-outstanding-request registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= RUN;
            pc_r     <= align_pc(RESET_PC);
            req_pc_r <= {PC_W{1'b0}};
        end else begin
            state_r <= state_n_s;
            pc_r    <= pc_n_s;
            if (issue_s) begin
                req_pc_r <= pc_r;
            end else begin
                req_pc_r <= req_pc_r;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PC_W + INS_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push_s),
        .push_data  ({req_pc_r, fetch_bus.imem_rdata}),
        .pop        (pop_s),
        .count      (count_s),
        .head_valid (head_valid_s),
        .head_data  (head_data_s)
    );

    assign fetch_bus.id_valid = head_valid_s;
    assign fetch_bus.id_pc    = head_data_s[INS_W +: PC_W];
    assign fetch_bus.id_instr = head_data_s[INS_W-1:0];

`ifdef FETCH_PERF_EN
    // Delivered-instruction and decode-starved-cycle counters (wrap at 2^32)
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= 32'd0;
            perf_bubble  <= 32'd0;
        end else begin
            if (pop_s) begin
                perf_fetched <= perf_fetched + 32'd1;
            end else begin
                perf_fetched <= perf_fetched;
            end
            if (fetch_bus.id_ready && !head_valid_s) begin
                perf_bubble <= perf_bubble + 32'd1;
            end else begin
                perf_bubble <= perf_bubble;
            end
        end
    end
`endif

endmodule
